rf_port_scheduler: RTL and testbench

Shares the 32x32 dual-read register file between two requesters: requester 0 (control unit) and requester 1 (debug/scan port). Each requester uses a valid/ready handshake. The scheduler arbitrates round-robin, issues at most one read or one write per cycle, and returns read data one cycle after issue. After every reset it walks all 32 registers and writes zero, so the file starts in a known state.

---
 rtl/rf_port_scheduler_pkg.sv | 18 +
 rtl/rf_port_scheduler_if.sv | 51 +++++
 rtl/rf_port_scheduler_rr_arbiter_2.sv | 30 +++
 rtl/rf_port_scheduler.sv | 140 ++++++++++++++
 tb/tb_rf_port_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_port_scheduler_pkg.sv
// rf_port_scheduler_pkg
//   Shared definitions for the register-file port scheduler: default data and
//   address widths, the FSM state encoding and the request opcode values.
package rf_port_scheduler_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Value of req_we_* selecting a read or a write.
  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/rf_port_scheduler_if.sv
// rf_port_scheduler_if
//   Bundles the two requester channels and the register-file port.
//   Handshake: a request transfers in any cycle where req_valid_r & req_ready_r.
//   A requester holds valid and its payload until the transfer and never lets
//   valid depend on ready; ready may depend on both valids. rsp_valid_r is a
//   one-cycle pulse one cycle after a read transfer; writes get no response.
//   Modports:
//     slave  - the scheduler
//     master - requesters plus the register file (the environment)
interface rf_port_scheduler_if
  import rf_port_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  req_valid_0, req_ready_0, req_we_0;
  logic [ADDR_WIDTH-1:0] req_addr1_0, req_addr2_0;
  logic [DATA_WIDTH-1:0] req_wdata_0;
  logic                  rsp_valid_0;
  logic [DATA_WIDTH-1:0] rsp_data1_0, rsp_data2_0;

  logic                  req_valid_1, req_ready_1, req_we_1;
  logic [ADDR_WIDTH-1:0] req_addr1_1, req_addr2_1;
  logic [DATA_WIDTH-1:0] req_wdata_1;
  logic                  rsp_valid_1;
  logic [DATA_WIDTH-1:0] rsp_data1_1, rsp_data2_1;

  logic                  rf_read, rf_write;
  logic [ADDR_WIDTH-1:0] rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [DATA_WIDTH-1:0] rf_data_w;
  logic [DATA_WIDTH-1:0] rf_data_r1, rf_data_r2;

  modport slave (
    input  req_valid_0, req_we_0, req_addr1_0, req_addr2_0, req_wdata_0,
    input  req_valid_1, req_we_1, req_addr1_1, req_addr2_1, req_wdata_1,
    input  rf_data_r1, rf_data_r2,
    output req_ready_0, rsp_valid_0, rsp_data1_0, rsp_data2_0,
    output req_ready_1, rsp_valid_1, rsp_data1_1, rsp_data2_1,
    output rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
  );

  modport master (
    output req_valid_0, req_we_0, req_addr1_0, req_addr2_0, req_wdata_0,
    output req_valid_1, req_we_1, req_addr1_1, req_addr2_1, req_wdata_1,
    output rf_data_r1, rf_data_r2,
    input  req_ready_0, rsp_valid_0, rsp_data1_0, rsp_data2_0,
    input  req_ready_1, rsp_valid_1, rsp_data1_1, rsp_data2_1,
    input  rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
  );

endinterface

// File: rtl/rf_port_scheduler_rr_arbiter_2.sv
// rr_arbiter_2
//   Two-way round-robin arbiter.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset (prio -> 0)
//     valid[1:0]- request lines
//     advance   - a granted request transferred this cycle
//     grant[1:0]- one-hot (or zero) grant, combinational from valid and prio
//     prio      - requester that wins when both are valid
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       prio
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

  // After a transfer the other requester gets priority: granting 0 hands
  // priority to 1 and vice versa.
  always_ff @(posedge clk) begin
    if (rst)          prio <= 1'b0;
    else if (advance) prio <= grant[0];
  end

endmodule

// File: rtl/rf_port_scheduler.sv
// rf_port_scheduler
//   Shares a dual-read register file between requester 0 (control unit) and
//   requester 1 (debug/scan). After reset it optionally zero-fills every
//   register (CLEAR), then arbitrates round-robin (RUN), issuing one read or
//   one write per cycle. Read data is registered and returned one cycle later.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     bus       - requester channels and register-file port (slave modport)
//     busy      - high while the zero-fill sweep runs
//     state_dbg - current FSM state
//     prio_dbg  - requester currently holding round-robin priority
module rf_port_scheduler
  import rf_port_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_port_scheduler_if.slave   bus,
  output logic                 busy,
  output state_e               state_dbg,
  output logic                 prio_dbg
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]            valid, grant;
  logic                  run;
  logic                  rd_0, rd_1;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
      else                state_q <= ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign busy      = (state_q == ST_CLEAR);
  assign state_dbg = state_q;

  // ---------------- Arbitration ----------------
  // Requests are hidden from the arbiter during CLEAR so no ready is raised.
  assign valid = {bus.req_valid_1, bus.req_valid_0} & {2{run}};

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .advance (|grant),
    .grant   (grant),
    .prio    (prio_dbg)
  );

  assign bus.req_ready_0 = grant[0];
  assign bus.req_ready_1 = grant[1];

  // ---------------- Register-file issue mux ----------------
  always_comb begin
    bus.rf_read    = 1'b0;
    bus.rf_write   = 1'b0;
    bus.rf_addr_r1 = '0;
    bus.rf_addr_r2 = '0;
    bus.rf_addr_w  = '0;
    bus.rf_data_w  = '0;
    if (busy) begin
      bus.rf_write  = 1'b1;
      bus.rf_addr_w = clr_cnt_q;
    end else if (grant[0]) begin
      if (bus.req_we_0 == REQ_WR) begin
        bus.rf_write  = 1'b1;
        bus.rf_addr_w = bus.req_addr1_0;
        bus.rf_data_w = bus.req_wdata_0;
      end else begin
        bus.rf_read    = 1'b1;
        bus.rf_addr_r1 = bus.req_addr1_0;
        bus.rf_addr_r2 = bus.req_addr2_0;
      end
    end else if (grant[1]) begin
      if (bus.req_we_1 == REQ_WR) begin
        bus.rf_write  = 1'b1;
        bus.rf_addr_w = bus.req_addr1_1;
        bus.rf_data_w = bus.req_wdata_1;
      end else begin
        bus.rf_read    = 1'b1;
        bus.rf_addr_r1 = bus.req_addr1_1;
        bus.rf_addr_r2 = bus.req_addr2_1;
      end
    end
  end

  // ---------------- Read responses ----------------
  assign rd_0 = grant[0] & (bus.req_we_0 == REQ_RD);
  assign rd_1 = grant[1] & (bus.req_we_1 == REQ_RD);

  // Data registers only load on a read for their own requester so the last
  // result stays visible until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid_0 <= 1'b0;
      bus.rsp_valid_1 <= 1'b0;
      bus.rsp_data1_0 <= '0;
      bus.rsp_data2_0 <= '0;
      bus.rsp_data1_1 <= '0;
      bus.rsp_data2_1 <= '0;
    end else begin
      bus.rsp_valid_0 <= rd_0;
      bus.rsp_valid_1 <= rd_1;
      if (rd_0) begin
        bus.rsp_data1_0 <= bus.rf_data_r1;
        bus.rsp_data2_0 <= bus.rf_data_r2;
      end
      if (rd_1) begin
        bus.rsp_data1_1 <= bus.rf_data_r1;
        bus.rsp_data2_1 <= bus.rf_data_r2;
      end
    end
  end

endmodule

// File: tb/tb_rf_port_scheduler.sv
// tb_rf_port_scheduler
//   Directed bench for rf_port_scheduler with a behavioural 32x32 register
//   file attached to the RF port.
module tb_rf_port_scheduler;
  import rf_port_scheduler_pkg::*;

  // ---------------- Clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   busy, prio_dbg;
  state_e state_dbg;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  rf_port_scheduler_if bus ();

  rf_port_scheduler #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg),
    .prio_dbg  (prio_dbg)
  );

  // Register file model; non-zero power-up contents expose a missing sweep.
  logic [31:0] rf_mem [32] = '{default: 32'hA5A5_5A5A};
  assign bus.rf_data_r1 = rf_mem[bus.rf_addr_r1];
  assign bus.rf_data_r2 = rf_mem[bus.rf_addr_r2];
  always @(posedge clk) if (bus.rf_write) rf_mem[bus.rf_addr_w] <= bus.rf_data_w;

  // ---------------- Driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid_0 = 1'b0; bus.req_we_0 = 1'b0;
    bus.req_addr1_0 = '0;   bus.req_addr2_0 = '0; bus.req_wdata_0 = '0;
    bus.req_valid_1 = 1'b0; bus.req_we_1 = 1'b0;
    bus.req_addr1_1 = '0;   bus.req_addr2_1 = '0; bus.req_wdata_1 = '0;
  endtask

  task automatic req0(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] wd);
    bus.req_valid_0 = 1'b1; bus.req_we_0 = we;
    bus.req_addr1_0 = a1; bus.req_addr2_0 = a2; bus.req_wdata_0 = wd;
  endtask

  task automatic req1(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] wd);
    bus.req_valid_1 = 1'b1; bus.req_we_1 = we;
    bus.req_addr1_1 = a1; bus.req_addr2_1 = a2; bus.req_wdata_1 = wd;
  endtask

  // ---------------- Checkers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle();
    next(); next();
    #1;
    // Reset state
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_state", state_dbg, ST_CLEAR);
    chk1("rst_prio", prio_dbg, 1'b0);
    chk1("rst_rsp_valid_0", bus.rsp_valid_0, 1'b0);
    chk1("rst_rsp_valid_1", bus.rsp_valid_1, 1'b0);
    chk("rst_rsp_data1_0", bus.rsp_data1_0, 32'h0);
    chk("rst_rsp_data2_1", bus.rsp_data2_1, 32'h0);

    // Sweep: a read request waits through all 32 CLEAR cycles.
    rst = 1'b0;
    req0(REQ_RD, 5'd7, 5'd31, 32'h0);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin next(); #1; end
      chk1("clr_busy", busy, 1'b1);
      chk1("clr_rf_write", bus.rf_write, 1'b1);
      chk1("clr_rf_read", bus.rf_read, 1'b0);
      chk("clr_addr_w", 32'(bus.rf_addr_w), 32'(i));
      chk("clr_data_w", bus.rf_data_w, 32'h0);
      chk1("clr_ready_0", bus.req_ready_0, 1'b0);
    end

    // Cycle 33: first possible ready
    next(); #1;
    chk1("run_busy", busy, 1'b0);
    chk1("first_ready_0", bus.req_ready_0, 1'b1);
    chk1("first_rf_read", bus.rf_read, 1'b1);
    chk1("first_rf_write", bus.rf_write, 1'b0);
    chk("first_addr_r1", 32'(bus.rf_addr_r1), 32'd7);
    chk("first_addr_r2", 32'(bus.rf_addr_r2), 32'd31);

    next(); idle(); #1;
    chk1("first_rsp_valid", bus.rsp_valid_0, 1'b1);
    chk("first_rsp_d1", bus.rsp_data1_0, 32'h0);
    chk("first_rsp_d2", bus.rsp_data2_0, 32'h0);
    chk1("idle_ready_0", bus.req_ready_0, 1'b0);
    chk1("idle_rf_read", bus.rf_read, 1'b0);
    chk1("idle_rf_write", bus.rf_write, 1'b0);
    chk("idle_addr_r1", 32'(bus.rf_addr_r1), 32'd0);
    chk("idle_addr_w", 32'(bus.rf_addr_w), 32'd0);
    chk("idle_data_w", bus.rf_data_w, 32'h0);

    // Write 0xDEADBEEF to r5, read it back next cycle
    next(); req0(REQ_WR, 5'd5, 5'd0, 32'hDEAD_BEEF); #1;
    chk1("rsp_pulse_end", bus.rsp_valid_0, 1'b0);
    chk1("wr_ready_0", bus.req_ready_0, 1'b1);
    chk1("wr_rf_write", bus.rf_write, 1'b1);
    chk1("wr_rf_read", bus.rf_read, 1'b0);
    chk("wr_addr_w", 32'(bus.rf_addr_w), 32'd5);
    chk("wr_data_w", bus.rf_data_w, 32'hDEAD_BEEF);

    next(); req0(REQ_RD, 5'd5, 5'd0, 32'h0); #1;
    chk1("wr_no_rsp", bus.rsp_valid_0, 1'b0);
    chk1("raw_rf_read", bus.rf_read, 1'b1);
    chk("raw_addr_r1", 32'(bus.rf_addr_r1), 32'd5);

    next(); idle(); #1;
    chk1("raw_rsp_valid", bus.rsp_valid_0, 1'b1);
    chk("raw_rsp_d1", bus.rsp_data1_0, 32'hDEAD_BEEF);
    chk("raw_rsp_d2", bus.rsp_data2_0, 32'h0);

    // Requester 1 write r3 vs requester 0 read r3 with prio=1
    next(); req0(REQ_RD, 5'd3, 5'd5, 32'h0); req1(REQ_WR, 5'd3, 5'd0, 32'h1234_5678); #1;
    chk1("hold_rsp_valid", bus.rsp_valid_0, 1'b0);
    chk("hold_rsp_d1", bus.rsp_data1_0, 32'hDEAD_BEEF);
    chk1("prio_before", prio_dbg, 1'b1);
    chk1("p1_ready_1", bus.req_ready_1, 1'b1);
    chk1("p1_ready_0", bus.req_ready_0, 1'b0);
    chk1("p1_rf_write", bus.rf_write, 1'b1);
    chk("p1_addr_w", 32'(bus.rf_addr_w), 32'd3);
    chk("p1_data_w", bus.rf_data_w, 32'h1234_5678);

    next(); bus.req_valid_1 = 1'b0; #1;
    chk1("p1_rd_ready_0", bus.req_ready_0, 1'b1);
    chk1("p1_rd_rf_read", bus.rf_read, 1'b1);
    chk("p1_rd_addr_r1", 32'(bus.rf_addr_r1), 32'd3);

    // Requester 1 read alone, leaving prio=0 for the contention run
    next(); idle(); req1(REQ_RD, 5'd5, 5'd3, 32'h0); #1;
    chk1("p1_rsp_valid_0", bus.rsp_valid_0, 1'b1);
    chk1("p1_rsp_valid_1", bus.rsp_valid_1, 1'b0);
    chk("p1_rsp_d1", bus.rsp_data1_0, 32'h1234_5678);
    chk("p1_rsp_d2", bus.rsp_data2_0, 32'hDEAD_BEEF);
    chk1("solo_ready_1", bus.req_ready_1, 1'b1);

    // Contention: both hold reads for 6 cycles
    next(); req0(REQ_RD, 5'd5, 5'd3, 32'h0); req1(REQ_RD, 5'd3, 5'd0, 32'h0); #1;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) begin next(); #1; end
      chk1("ct_ready_0", bus.req_ready_0, (j % 2) == 0);
      chk1("ct_ready_1", bus.req_ready_1, (j % 2) == 1);
      chk("ct_addr_r1", 32'(bus.rf_addr_r1), ((j % 2) == 0) ? 32'd5 : 32'd3);
      chk1("ct_rsp_valid_0", bus.rsp_valid_0, (j > 0) && (((j - 1) % 2) == 0));
      chk1("ct_rsp_valid_1", bus.rsp_valid_1, (j == 0) || (((j - 1) % 2) == 1));
      if (j > 0 && ((j - 1) % 2) == 0) begin
        chk("ct_rsp_d1_0", bus.rsp_data1_0, 32'hDEAD_BEEF);
        chk("ct_rsp_d2_0", bus.rsp_data2_0, 32'h1234_5678);
      end else begin
        chk("ct_rsp_d1_1", bus.rsp_data1_1, (j == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
        chk("ct_rsp_d2_1", bus.rsp_data2_1, (j == 0) ? 32'h1234_5678 : 32'h0);
      end
    end
    next(); idle(); #1;
    chk1("ct_last_valid_1", bus.rsp_valid_1, 1'b1);
    chk1("ct_last_valid_0", bus.rsp_valid_0, 1'b0);
    chk("ct_last_d1_1", bus.rsp_data1_1, 32'h1234_5678);
    chk1("ct_prio_after", prio_dbg, 1'b0);

    // Reset with a read transfer in flight: response is dropped
    next(); req0(REQ_RD, 5'd5, 5'd3, 32'h0); rst = 1'b1; #1;
    next(); rst = 1'b0; idle(); #1;
    chk1("drop_rsp_valid_0", bus.rsp_valid_0, 1'b0);
    chk("drop_rsp_d1_0", bus.rsp_data1_0, 32'h0);
    chk("drop_rsp_d2_0", bus.rsp_data2_0, 32'h0);
    chk("drop_rsp_d1_1", bus.rsp_data1_1, 32'h0);
    chk1("drop_prio", prio_dbg, 1'b0);
    chk1("drop_busy", busy, 1'b1);
    chk("drop_addr_w", 32'(bus.rf_addr_w), 32'd0);

    // Reset mid-sweep at address 17
    for (int i = 1; i <= 17; i++) begin
      next(); #1;
      chk("sw1_addr_w", 32'(bus.rf_addr_w), 32'(i));
    end
    rst = 1'b1;
    next(); rst = 1'b0; #1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin next(); #1; end
      chk1("sw2_busy", busy, 1'b1);
      chk("sw2_addr_w", 32'(bus.rf_addr_w), 32'(i));
    end
    next(); #1;
    chk1("sw2_done_busy", busy, 1'b0);
    chk1("sw2_done_state", state_dbg, ST_RUN);
    chk1("sw2_idle_ready_0", bus.req_ready_0, 1'b0);
    chk1("sw2_idle_ready_1", bus.req_ready_1, 1'b0);
    chk1("sw2_idle_rf_write", bus.rf_write, 1'b0);

    // ---------------- Report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
